// File: rtl/turbo_deinterleaver.sv
// Serial LTE QPP turbo de-interleaver. Input bit i is written to address pi(i) of one bank
// of a two-bank ping-pong bit RAM, and full banks are read back in natural order 0..K-1.
// pi is stepped with two mod-K accumulators, so there are no multipliers.
module turbo_deinterleaver #(
  parameter int unsigned K_SHORT  = 1056,
  parameter int unsigned F1_SHORT = 17,
  parameter int unsigned F2_SHORT = 66,
  parameter int unsigned K_LONG   = 6144,
  parameter int unsigned F1_LONG  = 263,
  parameter int unsigned F2_LONG  = 480,
  parameter int unsigned AW       = 13
) (
  input  logic clk,
  input  logic reset_async,
  input  logic dataIn,
  input  logic look_now_in,
  input  logic flag_long_in,
  output logic dataOut,
  output logic valid_out,
  output logic look_now_out,
  output logic flag_long_out,
  output logic overflow
);

  typedef enum logic [1:0] {BankFree, BankWriting, BankFull, BankReading} bank_state_e;

  localparam logic [AW:0]   KS_W     = (AW+1)'(K_SHORT);
  localparam logic [AW:0]   KL_W     = (AW+1)'(K_LONG);
  localparam logic [AW-1:0] KS_M1    = AW'(K_SHORT - 1);
  localparam logic [AW-1:0] KL_M1    = AW'(K_LONG - 1);
  localparam int unsigned   G0S      = (F1_SHORT + F2_SHORT) % K_SHORT;
  localparam int unsigned   DS       = (2 * F2_SHORT) % K_SHORT;
  localparam int unsigned   G0L      = (F1_LONG + F2_LONG) % K_LONG;
  localparam int unsigned   DL       = (2 * F2_LONG) % K_LONG;
  localparam logic [AW-1:0] G0_SHORT = AW'(G0S);
  localparam logic [AW-1:0] G1_SHORT = AW'((G0S + DS) % K_SHORT);
  localparam logic [AW-1:0] D_SHORT  = AW'(DS);
  localparam logic [AW-1:0] G0_LONG  = AW'(G0L);
  localparam logic [AW-1:0] G1_LONG  = AW'((G0L + DL) % K_LONG);
  localparam logic [AW-1:0] D_LONG   = AW'(DL);

  // Both operands are < k, so one conditional subtract suffices.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW:0] k);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= k) sum = sum - k;
    return sum[AW-1:0];
  endfunction

  logic mem [2**(AW+1)];

  bank_state_e     bank_q [2];
  logic            bank_long_q [2];
  logic            older_q;      // bank that went FULL first when both are FULL
  logic            wr_active_q, wr_bank_q, wr_long_q;
  logic [AW-1:0]   wr_cnt_q, pi_q, g_q;
  logic            rd_valid_q, rd_bank_q, rd_long_q;
  logic [AW-1:0]   rd_addr_q;

  logic            free_avail, free_bank, start_ok, start_bank, wr_en, wr_bank, wr_last;
  logic [AW-1:0]   wr_addr, wr_k_m1, pi_next, g_next, rd_k_m1, rd_next_addr;
  logic            full0, full1, rd_busy, rd_start, rd_pick, rd_last_issue;

  // Writer address stepping and bank selection
  always_comb begin
    free_avail = (bank_q[0] == BankFree) || (bank_q[1] == BankFree);
    free_bank  = (bank_q[0] == BankFree) ? 1'b0 : 1'b1;
    start_ok   = look_now_in && (wr_active_q || free_avail);
    start_bank = wr_active_q ? wr_bank_q : free_bank;
    wr_en      = start_ok || wr_active_q;
    wr_bank    = look_now_in ? start_bank : wr_bank_q;
    wr_addr    = look_now_in ? '0 : pi_q;
    wr_k_m1    = wr_long_q ? KL_M1 : KS_M1;
    pi_next    = mod_add(pi_q, g_q, wr_long_q ? KL_W : KS_W);
    g_next     = mod_add(g_q, wr_long_q ? D_LONG : D_SHORT, wr_long_q ? KL_W : KS_W);
    wr_last    = wr_active_q && !look_now_in && (wr_cnt_q == wr_k_m1);
  end

  // Reader sequencing: oldest FULL bank first, next bank starts right after the last address
  always_comb begin
    full0         = (bank_q[0] == BankFull);
    full1         = (bank_q[1] == BankFull);
    rd_k_m1       = rd_long_q ? KL_M1 : KS_M1;
    rd_busy       = rd_valid_q && (rd_addr_q != rd_k_m1);
    rd_pick       = (full0 && full1) ? older_q : full1;
    rd_start      = !rd_busy && (full0 || full1);
    rd_next_addr  = rd_addr_q + 1'b1;
    rd_last_issue = rd_busy && (rd_next_addr == rd_k_m1);
  end

  // Bank state, writer and reader control
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      bank_q[0]      <= BankFree;
      bank_q[1]      <= BankFree;
      bank_long_q[0] <= 1'b0;
      bank_long_q[1] <= 1'b0;
      older_q        <= 1'b0;
      wr_active_q    <= 1'b0;
      wr_bank_q      <= 1'b0;
      wr_long_q      <= 1'b0;
      wr_cnt_q       <= '0;
      pi_q           <= '0;
      g_q            <= '0;
      rd_valid_q     <= 1'b0;
      rd_bank_q      <= 1'b0;
      rd_long_q      <= 1'b0;
      rd_addr_q      <= '0;
      overflow       <= 1'b0;
    end else begin
      overflow <= look_now_in && !wr_active_q && !free_avail;
      // A new block (claim or abort-restart) wins over continuing the current one
      if (start_ok) begin
        wr_active_q             <= 1'b1;
        wr_bank_q               <= start_bank;
        wr_long_q               <= flag_long_in;
        wr_cnt_q                <= AW'(1);
        pi_q                    <= flag_long_in ? G0_LONG : G0_SHORT;
        g_q                     <= flag_long_in ? G1_LONG : G1_SHORT;
        bank_q[start_bank]      <= BankWriting;
        bank_long_q[start_bank] <= flag_long_in;
      end else if (wr_active_q) begin
        pi_q     <= pi_next;
        g_q      <= g_next;
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_last) begin
          wr_active_q       <= 1'b0;
          bank_q[wr_bank_q] <= BankFull;
          if (bank_q[~wr_bank_q] != BankFull) older_q <= wr_bank_q;
        end
      end
      // Writer and reader never touch the same bank in the same cycle: their states differ
      if (rd_busy) begin
        rd_addr_q <= rd_next_addr;
        if (rd_last_issue) bank_q[rd_bank_q] <= BankFree;
      end else if (rd_start) begin
        rd_valid_q      <= 1'b1;
        rd_bank_q       <= rd_pick;
        rd_long_q       <= bank_long_q[rd_pick];
        rd_addr_q       <= '0;
        bank_q[rd_pick] <= BankReading;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  // Bit RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= dataIn;
  end

  // Registered read port and output flags
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      dataOut       <= 1'b0;
      valid_out     <= 1'b0;
      look_now_out  <= 1'b0;
      flag_long_out <= 1'b0;
    end else begin
      dataOut       <= rd_valid_q && mem[{rd_bank_q, rd_addr_q}];
      valid_out     <= rd_valid_q;
      look_now_out  <= rd_valid_q && (rd_addr_q == '0);
      flag_long_out <= rd_valid_q && rd_long_q;
    end
  end

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Directed bench for turbo_deinterleaver: impulses, round trip, overflow, abort, reset.
module tb_turbo_deinterleaver;
  localparam int KS = 1056;
  localparam int KL = 6144;

  logic clk = 1'b0;
  logic reset_async, dataIn, look_now_in, flag_long_in;
  logic dataOut, valid_out, look_now_out, flag_long_out, overflow;

  turbo_deinterleaver dut (
    .clk           (clk),
    .reset_async   (reset_async),
    .dataIn        (dataIn),
    .look_now_in   (look_now_in),
    .flag_long_in  (flag_long_in),
    .dataOut       (dataOut),
    .valid_out     (valid_out),
    .look_now_out  (look_now_out),
    .flag_long_out (flag_long_out),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_total = 0;
  logic in_buf [KL];
  logic orig [KL];
  logic exp_q [$];
  logic q_bits [$];
  int   q_cyc [$];
  int   q_sof [$];
  logic q_sof_flag [$];
  logic cur_flag = 1'b0;
  int   flag_err = 0;
  int   ovf_cnt = 0;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (valid_out) begin
      q_bits.push_back(dataOut);
      q_cyc.push_back(cyc);
      if (look_now_out) begin
        q_sof.push_back(cyc);
        q_sof_flag.push_back(flag_long_out);
        cur_flag = flag_long_out;
      end else if (flag_long_out !== cur_flag) begin
        flag_err++;
      end
    end
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int pi_f(input int i, input bit lng);
    longint k, f1, f2, ii;
    k  = lng ? 6144 : 1056;
    f1 = lng ? 263 : 17;
    f2 = lng ? 480 : 66;
    ii = longint'(i);
    return int'((f1 * ii + f2 * ii * ii) % k);
  endfunction

  function automatic int sof_at(input int n);
    return (n < q_sof.size()) ? q_sof[n] : -1;
  endfunction

  function automatic int bit_at(input int n);
    return (n < q_bits.size()) ? int'(q_bits[n]) : -1;
  endfunction

  function automatic int ones();
    int s = 0;
    foreach (q_bits[i]) s += int'(q_bits[i]);
    return s;
  endfunction

  task automatic clear_q();
    q_bits.delete(); q_cyc.delete(); q_sof.delete(); q_sof_flag.delete(); exp_q.delete();
  endtask

  // Random natural-order block, interleaved into in_buf; optionally expected at the output
  task automatic prep(input bit lng, input bit keep);
    int k = lng ? KL : KS;
    for (int i = 0; i < k; i++) orig[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < k; i++) in_buf[i] = orig[pi_f(i, lng)];
    if (keep) for (int i = 0; i < k; i++) exp_q.push_back(orig[i]);
  endtask

  task automatic send(input bit lng, input int nbits, output int e0);
    @(negedge clk);
    look_now_in  = 1'b1;
    flag_long_in = lng;
    dataIn       = in_buf[0];
    e0           = cyc + 1;
    for (int j = 1; j < nbits; j++) begin
      @(negedge clk);
      look_now_in = 1'b0;
      dataIn      = in_buf[j];
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    look_now_in = 1'b0;
    dataIn      = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && q_bits.size() < n; c++) @(negedge clk);
    idle(5);
    chk(tag, q_bits.size(), n);
  endtask

  task automatic cmp_data(input string tag);
    int bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_bits.size() || q_bits[i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int e0, ea, eb, ec, ex, ovf0, ferr0;
    int eb_arr [4];
    bit lng_arr [4];
    lng_arr = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset_async = 1'b1; dataIn = 1'b0; look_now_in = 1'b0; flag_long_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dataOut", int'(dataOut), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_look_now_out", int'(look_now_out), 0);
    chk("rst_flag_long_out", int'(flag_long_out), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset_async = 1'b0;
    idle(3);

    // Short impulse: input bit 1 lands at output index pi(1)=83
    clear_q();
    for (int i = 0; i < KS; i++) in_buf[i] = 1'b0;
    in_buf[1] = 1'b1;
    ferr0 = flag_err;
    send(1'b0, KS, e0);
    wait_out("s_imp_count", KS, 3000);
    chk("s_imp_bit83", bit_at(83), 1);
    chk("s_imp_ones", ones(), 1);
    chk("s_imp_sof_cyc", sof_at(0), e0 + 1057);
    chk("s_imp_bit83_cyc", (q_cyc.size() > 83) ? q_cyc[83] : -1, e0 + 1057 + 83);
    chk("s_imp_sof_count", q_sof.size(), 1);
    chk("s_imp_flag", (q_sof_flag.size() > 0) ? int'(q_sof_flag[0]) : -1, 0);

    // Long impulse: input bit 2 lands at output index pi(2)=2446
    clear_q();
    for (int i = 0; i < KL; i++) in_buf[i] = 1'b0;
    in_buf[2] = 1'b1;
    send(1'b1, KL, e0);
    wait_out("l_imp_count", KL, 7000);
    chk("l_imp_bit2446", bit_at(2446), 1);
    chk("l_imp_ones", ones(), 1);
    chk("l_imp_sof_cyc", sof_at(0), e0 + KL + 1);
    chk("l_imp_flag", (q_sof_flag.size() > 0) ? int'(q_sof_flag[0]) : -1, 1);
    chk("flag_held", flag_err - ferr0, 0);

    // Round trip, back-to-back S,S,L,L: each block out K+1 after its first bit, gapless
    clear_q();
    ovf0 = ovf_cnt;
    for (int b = 0; b < 4; b++) begin
      prep(lng_arr[b], 1'b1);
      send(lng_arr[b], lng_arr[b] ? KL : KS, eb_arr[b]);
    end
    wait_out("rt_count", 2 * KS + 2 * KL, 8000);
    cmp_data("rt_data");
    chk("rt_sof_count", q_sof.size(), 4);
    for (int b = 0; b < 4; b++)
      chk($sformatf("rt_sof_cyc%0d", b), sof_at(b), eb_arr[b] + (lng_arr[b] ? KL : KS) + 1);
    chk("rt_no_overflow", ovf_cnt - ovf0, 0);

    // Overflow: long, short, then a third block while one bank reads and the other is full
    clear_q();
    ovf0 = ovf_cnt;
    prep(1'b1, 1'b1); send(1'b1, KL, ea);
    prep(1'b0, 1'b1); send(1'b0, KS, eb);
    prep(1'b0, 1'b0); send(1'b0, KS, ec);
    wait_out("ovf_count", KL + KS, 8000);
    cmp_data("ovf_data");
    chk("ovf_pulses", ovf_cnt - ovf0, 1);
    chk("ovf_sof_count", q_sof.size(), 2);
    chk("ovf_sof0_cyc", sof_at(0), ea + KL + 1);
    chk("ovf_sof1_cyc", sof_at(1), ea + 2 * KL + 1);
    chk("ovf_flag1", (q_sof_flag.size() > 1) ? int'(q_sof_flag[1]) : -1, 0);

    // Abort: short block restarted at bit 500 as a long block
    clear_q();
    ovf0 = ovf_cnt;
    prep(1'b0, 1'b0); send(1'b0, 500, ex);
    prep(1'b1, 1'b1); send(1'b1, KL, e0);
    wait_out("abort_count", KL, 8000);
    cmp_data("abort_data");
    chk("abort_sof_count", q_sof.size(), 1);
    chk("abort_sof_cyc", sof_at(0), e0 + KL + 1);
    chk("abort_no_overflow", ovf_cnt - ovf0, 0);

    // Reset mid-output, then a fresh short block
    clear_q();
    prep(1'b0, 1'b0); send(1'b0, KS, ex);
    idle(1);
    for (int c = 0; c < 2000 && q_bits.size() < 100; c++) @(negedge clk);
    chk("pre_rst_valid", int'(valid_out), 1);
    #2 reset_async = 1'b1;
    #1;
    chk("mid_rst_dataOut", int'(dataOut), 0);
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_look_now_out", int'(look_now_out), 0);
    chk("mid_rst_flag_long_out", int'(flag_long_out), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    @(negedge clk);
    reset_async = 1'b0;
    idle(2);
    clear_q();
    prep(1'b0, 1'b1); send(1'b0, KS, e0);
    wait_out("post_rst_count", KS, 3000);
    cmp_data("post_rst_data");
    chk("post_rst_sof_cyc", sof_at(0), e0 + KS + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
